// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl
// Drives a Width*Words-bit addition through a Width-bit asynchronous adder
// responder. The operation runs one slice at a time, least significant slice
// first. Each slice uses a req/fin handshake, and the carry is propagated
// locally between slices.
//
// Ports
//   clk, rst_n       : system clock (rising edge), async active-low reset
//   start            : begin an operation (only sampled while idle)
//   a, b, cin        : operands and carry-in; hold stable while busy
//   busy, done, err  : status; done is a one-cycle pulse, err flags a timeout
//   sum, cout        : result, held until the next accepted start
//   req, x, y        : request and operand slice to the responder
//   so, couto, fin   : responder sum, carry and completion pulse
module add_seq_ctrl #(
    parameter int Width   = 32,
    parameter int Words   = 4,
    parameter int Timeout = 255,
    parameter int ReqLow  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [Width*Words-1:0]   a,
    input  logic [Width*Words-1:0]   b,
    input  logic                     cin,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [Width*Words-1:0]   sum,
    output logic                     cout,
    output logic                     req,
    output logic [Width-1:0]         x,
    output logic [Width-1:0]         y,
    input  logic [Width-1:0]         so,
    input  logic                     couto,
    input  logic                     fin
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LAUNCH  = 3'd1;
    localparam logic [2:0] S_REQ     = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;
    localparam logic [2:0] S_FINISH  = 3'd5;

    localparam int CntW = $clog2(Timeout + ReqLow + 1);
    localparam int IdxW = (Words > 1) ? $clog2(Words) : 1;

    localparam logic [CntW-1:0] TO_LAST  = CntW'(Timeout - 1);
    localparam logic [CntW-1:0] REL_LAST = CntW'(ReqLow - 2);
    localparam logic [IdxW-1:0] IDX_LAST = IdxW'(Words - 1);

    // The carry out of a slice is the responder carry. It is also set when the
    // responder sum is all ones and an incoming carry ripples through it.
    function automatic logic slice_carry(input logic [Width-1:0] s,
                                         input logic             co,
                                         input logic             ci);
        return co | ((&s) & ci);
    endfunction

    logic [2:0]             r_state;
    logic [IdxW-1:0]        r_idx;
    logic [CntW-1:0]        r_cnt;
    logic                   r_carry;
    logic                   r_req;
    logic [Width-1:0]       r_x;
    logic [Width-1:0]       r_y;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_err;
    logic [Width*Words-1:0] r_sum;
    logic                   r_cout;

    logic                   r_fin_tgl;
    logic                   r_fin_s1;
    logic                   r_fin_s2;
    logic                   r_fin_hist;

    logic                   w_fin_seen;
    logic [Width-1:0]       w_a_slice;
    logic [Width-1:0]       w_b_slice;
    logic [Width-1:0]       w_sum_slice;
    logic                   w_carry_next;

    assign w_fin_seen   = r_fin_s2 ^ r_fin_hist;
    assign w_a_slice    = a[r_idx*Width +: Width];
    assign w_b_slice    = b[r_idx*Width +: Width];
    assign w_sum_slice  = so + Width'(r_carry);
    assign w_carry_next = slice_carry(so, couto, r_carry);

    // fin is too short to sample with clk. Each pulse flips this flop instead.
    always_ff @(posedge fin or negedge rst_n) begin
        if (!rst_n) begin
            r_fin_tgl <= 1'b0;
        end else begin
            r_fin_tgl <= ~r_fin_tgl;
        end
    end

    // Bring the toggle into the clk domain and keep one history stage for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fin_s1   <= 1'b0;
            r_fin_s2   <= 1'b0;
            r_fin_hist <= 1'b0;
        end else begin
            r_fin_s1   <= r_fin_tgl;
            r_fin_s2   <= r_fin_s1;
            r_fin_hist <= r_fin_s2;
        end
    end

    // Sequencer: runs the slice handshakes and the carry chain, and registers every output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_req   <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sum   <= '0;
                        r_err   <= 1'b0;
                        r_cout  <= 1'b0;
                        r_carry <= cin;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        // Operands are driven on entry to LAUNCH. x/y are then settled a full cycle before req rises.
                        r_x     <= a[Width-1:0];
                        r_y     <= b[Width-1:0];
                        r_state <= S_LAUNCH;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_LAUNCH: begin
                    r_req   <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= S_REQ;
                end
                S_REQ: begin
                    if (w_fin_seen) begin
                        r_req   <= 1'b0;
                        r_state <= S_CAPTURE;
                    end else if (r_cnt == TO_LAST) begin
                        r_req   <= 1'b0;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_FINISH;
                    end else begin
                        r_cnt   <= r_cnt + CntW'(1);
                    end
                end
                S_CAPTURE: begin
                    r_sum[r_idx*Width +: Width] <= w_sum_slice;
                    r_carry <= w_carry_next;
                    if (r_idx == IDX_LAST) begin
                        r_cout  <= w_carry_next;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_FINISH;
                    end else begin
                        r_idx   <= r_idx + IdxW'(1);
                        r_cnt   <= '0;
                        r_state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    // r_idx already points at the next slice here.
                    if (r_cnt == REL_LAST) begin
                        r_x     <= w_a_slice;
                        r_y     <= w_b_slice;
                        r_state <= S_LAUNCH;
                    end else begin
                        r_cnt   <= r_cnt + CntW'(1);
                    end
                end
                S_FINISH: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_req   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign err  = r_err;
    assign sum  = r_sum;
    assign cout = r_cout;
    assign req  = r_req;
    assign x    = r_x;
    assign y    = r_y;

endmodule
